// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer between spi_slave word streams and a simple register bus.
//
// Each chip-select frame begins with a command word {rnw, addr}. A write frame carries one
// data word that is strobed onto the register bus. A read frame fetches the register and
// pushes it into the spi_slave tx stream; the word the master clocks in meanwhile is dropped.
// A synchronised spi_cs_n high in any non-idle state returns the sequencer to idle.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   rx_tdata/tvalid/tready word stream from spi_slave
//   tx_tdata/tvalid/tready read data toward spi_slave
//   spi_cs_n               raw chip select, synchronised internally
//   reg_addr/wdata/we/re   register bus request side
//   reg_rdata              register bus read data, valid the cycle after reg_re
//   err_addr, err_clr      sticky out-of-range command flag and its clear
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   rx_tdata,
  input  logic              rx_tvalid,
  output logic              rx_tready,
  output logic [ADDR_W:0]   tx_tdata,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  input  logic              spi_cs_n,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [ADDR_W:0]   reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [ADDR_W:0]   reg_rdata,
  output logic              err_addr,
  input  logic              err_clr
);

  localparam int unsigned DataW = ADDR_W + 1;
  // Extra bit allows NUM_REGS == 2**ADDR_W to be represented.
  localparam logic [DataW-1:0] NumRegs = DataW'(NUM_REGS);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrData = 3'd1,
    StRdReq  = 3'd2,
    StRdWait = 3'd3,
    StTxPush = 3'd4,
    StDummy  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              cs_meta_q, cs_sync_q;
  logic              in_range_q, in_range_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DataW-1:0]  tx_data_q, tx_data_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              rx_hs;
  logic              abort;
  logic              cmd_in_range;

  // Two-flop synchroniser; resets to "deselected".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
    end else begin
      cs_meta_q <= spi_cs_n;
      cs_sync_q <= cs_meta_q;
    end
  end

  // Ready and read strobe depend on the registered state only.
  always_comb begin
    rx_tready = 1'b0;
    reg_re    = 1'b0;
    case (state_q)
      StIdle, StWrData, StDummy: rx_tready = 1'b1;
      StRdReq:                   reg_re    = in_range_q;
      default:                   ;
    endcase
  end

  assign rx_hs        = rx_tvalid & rx_tready;
  assign abort        = cs_sync_q;  // only acted on outside StIdle
  assign cmd_in_range = {1'b0, rx_tdata[ADDR_W-1:0]} < NumRegs;

  always_comb begin
    state_d    = state_q;
    in_range_d = in_range_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    err_set    = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_hs) begin
          addr_d     = rx_tdata[ADDR_W-1:0];
          in_range_d = cmd_in_range;
          err_set    = ~cmd_in_range;
          state_d    = rx_tdata[ADDR_W] ? StRdReq : StWrData;
        end
      end
      StWrData: begin
        // A data word arriving alongside an abort still completes the write.
        if (rx_hs) begin
          wdata_d = rx_tdata;
          we_d    = in_range_q;
          state_d = StIdle;
        end
        if (abort) state_d = StIdle;
      end
      StRdReq: begin
        state_d = abort ? StIdle : StRdWait;
      end
      StRdWait: begin
        tx_data_d = in_range_q ? reg_rdata : '0;
        if (abort) begin
          state_d = StIdle;
        end else begin
          tx_valid_d = 1'b1;
          state_d    = StTxPush;
        end
      end
      StTxPush: begin
        if (abort) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (tx_tready) begin
          tx_valid_d = 1'b0;
          state_d    = StDummy;
        end
      end
      StDummy: begin
        // Word shifted in while the read data went out carries no meaning.
        if (rx_hs || abort) state_d = StIdle;
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // Set takes priority over clear.
  assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_range_q <= in_range_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign tx_tvalid = tx_valid_q;
  assign tx_tdata  = tx_data_q;
  assign err_addr  = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frames, expected bus/tx events queued by the stimulus and
// consumed by an independent monitor.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;
  logic       spi_cs_n;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       err_addr;
  logic       err_clr;

  always #5 clk = ~clk;

  spi_reg_ctrl #(
    .ADDR_W   (7),
    .NUM_REGS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_tdata  (rx_tdata),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .spi_cs_n  (spi_cs_n),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  // Register-bus slave: data appears only the cycle after reg_re, garbage otherwise.
  logic [7:0] regs [16] = '{3: 8'h3C, default: 8'h00};
  always @(posedge clk) begin
    if (reg_we) regs[reg_addr[3:0]] <= reg_wdata;
    reg_rdata <= reg_re ? regs[reg_addr[3:0]] : 8'hEE;
  end

  typedef enum int {EvWe = 0, EvRe = 1, EvTx = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic we_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string nm, input ev_kind_e k, input logic [7:0] a,
                           input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event addr 0x%0h data 0x%0h, expected none", nm, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL %s: got kind %0d addr 0x%0h data 0x%0h expected kind %0d addr 0x%0h data 0x%0h",
                 nm, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: compares every bus strobe and tx handshake against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        chk("we_re_exclusive", {31'd0, reg_re}, 32'd0);
        chk("we_single_cycle", {31'd0, we_prev}, 32'd0);
        pop_check("bus_write", EvWe, {1'b0, reg_addr}, reg_wdata);
      end
      if (reg_re) pop_check("bus_read", EvRe, {1'b0, reg_addr}, 8'h00);
      if (tx_tvalid && tx_tready) pop_check("tx_word", EvTx, 8'h00, tx_tdata);
      we_prev = reg_we;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one rx word and returns 1ns after the handshake edge.
  task automatic send_word(input logic [7:0] d, input logic clr);
    int n = 0;
    rx_tdata  = d;
    rx_tvalid = 1'b1;
    err_clr   = clr;
    forever begin
      @(negedge clk);
      if (rx_tready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word 0x%0h not accepted, rx_tready %0b expected 1", d,
                 rx_tready);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic wait_tx_valid(input string nm);
    int n = 0;
    forever begin
      @(negedge clk);
      if (tx_tvalid) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL %s: tx_tvalid %0b expected 1 within 50 cycles", nm, tx_tvalid);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_rx_tready"}, {31'd0, rx_tready}, 32'd1);
    chk({nm, "_tx_tvalid"}, {31'd0, tx_tvalid}, 32'd0);
    chk({nm, "_tx_tdata"},  {24'd0, tx_tdata},  32'd0);
    chk({nm, "_reg_addr"},  {25'd0, reg_addr},  32'd0);
    chk({nm, "_reg_wdata"}, {24'd0, reg_wdata}, 32'd0);
    chk({nm, "_reg_we"},    {31'd0, reg_we},    32'd0);
    chk({nm, "_reg_re"},    {31'd0, reg_re},    32'd0);
    chk({nm, "_err_addr"},  {31'd0, err_addr},  32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_tdata  = 8'h00;
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    spi_cs_n  = 1'b1;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    spi_cs_n = 1'b0;
    tick(3);

    // Write 0xA5 to register 5.
    push(EvWe, 8'h05, 8'hA5);
    send_word(8'h05, 1'b0);
    send_word(8'hA5, 1'b0);
    @(negedge clk);
    chk("wr_we_next_cycle", {31'd0, reg_we}, 32'd1);
    chk("wr_addr", {25'd0, reg_addr}, 32'h05);
    chk("wr_wdata", {24'd0, reg_wdata}, 32'hA5);
    @(negedge clk);
    chk("wr_we_one_cycle", {31'd0, reg_we}, 32'd0);
    chk("wr_err_clear", {31'd0, err_addr}, 32'd0);
    @(posedge clk);
    #1;

    // Read register 3 with tx backpressure, then the dummy word.
    push(EvRe, 8'h03, 8'h00);
    push(EvTx, 8'h00, 8'h3C);
    send_word(8'h83, 1'b0);
    wait_tx_valid("rd_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", {31'd0, tx_tvalid}, 32'd1);
      chk("rd_hold_data", {24'd0, tx_tdata}, 32'h3C);
    end
    @(posedge clk);
    #1;
    tx_tready = 1'b1;
    send_word(8'hFF, 1'b0);
    tx_tready = 1'b0;
    tick(3);
    chk("rd_queue_drained", exp_q.size(), 32'd0);
    chk("rd_tx_released", {31'd0, tx_tvalid}, 32'd0);

    // Out-of-range read: no strobe, zero data, sticky error.
    tx_tready = 1'b1;
    push(EvTx, 8'h00, 8'h00);
    send_word(8'h90, 1'b0);
    send_word(8'h00, 1'b0);
    tx_tready = 1'b0;
    @(negedge clk);
    chk("oor_err_set", {31'd0, err_addr}, 32'd1);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("oor_err_cleared", {31'd0, err_addr}, 32'd0);
    @(posedge clk);
    #1;
    // Bad write command coincident with err_clr: error must stay set, no write strobe.
    send_word(8'h20, 1'b1);
    send_word(8'h55, 1'b0);
    tick(2);
    @(negedge clk);
    chk("oor_set_beats_clr", {31'd0, err_addr}, 32'd1);
    @(posedge clk);
    #1;

    // Abort a write frame before its data word.
    send_word(8'h02, 1'b0);
    spi_cs_n = 1'b1;
    tick(4);
    spi_cs_n = 1'b0;
    tick(3);
    push(EvWe, 8'h02, 8'h11);
    send_word(8'h02, 1'b0);
    send_word(8'h11, 1'b0);
    tick(2);
    chk("abort_wr_queue", exp_q.size(), 32'd0);

    // Abort while read data waits in TX_PUSH.
    push(EvRe, 8'h03, 8'h00);
    send_word(8'h83, 1'b0);
    wait_tx_valid("abort_tx_valid");
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_tx_dropped", {31'd0, tx_tvalid}, 32'd0);
    chk("abort_tx_idle", {31'd0, rx_tready}, 32'd1);
    @(posedge clk);
    #1;
    spi_cs_n = 1'b0;
    tick(3);
    tx_tready = 1'b1;
    push(EvRe, 8'h02, 8'h00);
    push(EvTx, 8'h00, 8'h11);
    send_word(8'h82, 1'b0);
    send_word(8'hAA, 1'b0);
    tx_tready = 1'b0;
    tick(2);
    chk("after_abort_queue", exp_q.size(), 32'd0);

    // Reset asserted while in RD_WAIT.
    push(EvRe, 8'h03, 8'h00);
    send_word(8'h83, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, rx_tready}, 32'd1);
    chk("rst_release_txv", {31'd0, tx_tvalid}, 32'd0);
    @(posedge clk);
    #1;
    tick(3);

    // Normal read after reset returns the earlier write.
    tx_tready = 1'b1;
    push(EvRe, 8'h05, 8'h00);
    push(EvTx, 8'h00, 8'hA5);
    send_word(8'h85, 1'b0);
    send_word(8'h00, 1'b0);
    tx_tready = 1'b0;
    tick(10);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
